outlier_reader: RTL and testbench

Drain engine on the read side of the validation controller's outlier FIFO. It issues `read_fifo` against the FIFO's `empty` flag and handles the FIFO's one-cycle read latency. Each outlier point position is presented on a valid/ready output stream toward the host DMA. Once the controller reports `done` and the FIFO is fully drained, it optionally appends a trailer beat carrying the total outlier count.

---
 rtl/denoise_pkg.sv | 25 ++
 rtl/pos_skid_buffer.sv | 56 +++++
 rtl/outlier_reader.sv | 131 +++++++++++++
 tb/tb_outlier_reader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/denoise_pkg.sv
// Shared types and defaults for the outlier drain path.
// State encoding, widths and the read-issue credit rule.
package denoise_pkg;

    localparam int POS_W      = 16;
    localparam int CNT_W      = 2 * POS_W;
    localparam int SETTLE_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_TRAILER,
        ST_DONE
    } reader_state_t;

    // Buffered plus in-flight reads may never exceed the 2-entry buffer.
    function automatic logic can_issue(
        input logic [1:0] occ,
        input logic       inflight
    );
        return ({1'b0, occ} + {2'b00, inflight}) < 3'd2;
    endfunction

endpackage

// File: rtl/pos_skid_buffer.sv
// Two-entry, order-preserving register buffer for point positions.
// Entry 0 is always the head; freed entries are zeroed.
module pos_skid_buffer #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic [W-1:0] e0;
    logic [W-1:0] e1;
    logic         pop_ok;

    assign pop_ok = pop && (occ != 2'd0);
    assign head   = e0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            e0  <= '0;
            e1  <= '0;
            occ <= 2'd0;
        end else begin
            case ({push, pop_ok})
                2'b11: begin
                    if (occ == 2'd1) begin
                        e0 <= push_data;
                    end else begin
                        e0 <= e1;
                        e1 <= push_data;
                    end
                end
                2'b01: begin
                    e0  <= e1;
                    e1  <= '0;
                    occ <= occ - 2'd1;
                end
                2'b10: begin
                    if (occ == 2'd0) begin
                        e0 <= push_data;
                    end else begin
                        e1 <= push_data;
                    end
                    occ <= occ + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/outlier_reader.sv
// Drains the outlier FIFO onto a valid/ready stream toward host DMA.
// Define OUTLIER_READER_TRAILER_EN to append a count trailer beat.
module outlier_reader
    import denoise_pkg::*;
#(
    parameter int N      = POS_W,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           ctrl_done,
    input  logic           fifo_empty,
    input  logic [N-1:0]   fifo_dout,
    output logic           fifo_rd_en,
    output logic [2*N-1:0] m_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic           m_last,
    output logic [2*N-1:0] outlier_count,
    output logic           busy,
    output logic           finished
);

    localparam int CW = 2 * N;
    localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);

    reader_state_t state;
    logic          inflight;
    logic [SW-1:0] settle;
    logic [CW-1:0] count;
    logic [1:0]    occ;
    logic [CW-1:0] head;
    logic          reading;
    logic          data_valid;
    logic          data_xfer;
    logic          trailer;
    logic          quiet;

    assign reading    = (state == ST_RUN) || (state == ST_FLUSH);
    assign fifo_rd_en = reading && !fifo_empty && can_issue(occ, inflight);
    assign data_valid = (occ != 2'd0);
    assign data_xfer  = data_valid && m_ready;
    assign quiet      = ctrl_done && fifo_empty && !inflight;

`ifdef OUTLIER_READER_TRAILER_EN
    assign trailer = (state == ST_TRAILER);
`else
    assign trailer = 1'b0;
`endif

    assign m_valid       = data_valid || trailer;
    assign m_data        = trailer ? count : head;
    assign m_last        = trailer;
    assign outlier_count = count;
    assign busy          = reading;
    assign finished      = (state == ST_DONE);

    pos_skid_buffer #(
        .W (CW)
    ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight),
        .push_data ({{N{1'b0}}, fifo_dout}),
        .pop       (data_xfer),
        .occ       (occ),
        .head      (head)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            inflight <= 1'b0;
            settle   <= '0;
            count    <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (data_xfer && (count != {CW{1'b1}})) begin
                count <= count + 1'b1;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state  <= ST_RUN;
                        settle <= '0;
                        count  <= '0;
                    end
                end
                ST_RUN: begin
                    settle <= '0;
                    if (ctrl_done) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!ctrl_done) begin
                        state  <= ST_RUN;
                        settle <= '0;
                    end else if ((settle == SETTLE_V) && !data_valid) begin
                        settle <= '0;
`ifdef OUTLIER_READER_TRAILER_EN
                        state  <= ST_TRAILER;
`else
                        state  <= ST_DONE;
`endif
                    end else if (quiet) begin
                        // Saturate so a busy output buffer can still drain.
                        if (settle != SETTLE_V) begin
                            settle <= settle + 1'b1;
                        end
                    end else begin
                        settle <= '0;
                    end
                end
`ifdef OUTLIER_READER_TRAILER_EN
                ST_TRAILER: begin
                    if (m_ready) begin
                        state <= ST_DONE;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_outlier_reader.sv
// Directed bench for outlier_reader with a one-cycle-latency FIFO model.
// Expectations adapt to whether the trailer feature is compiled in.
module tb_outlier_reader;

    localparam int N = 16;
`ifdef OUTLIER_READER_TRAILER_EN
    localparam bit TRL = 1'b1;
`else
    localparam bit TRL = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           ctrl_done = 1'b0;
    logic           fifo_empty;
    logic [N-1:0]   fifo_dout;
    logic           fifo_rd_en;
    logic [2*N-1:0] m_data;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic           m_last;
    logic [2*N-1:0] outlier_count;
    logic           busy;
    logic           finished;

    outlier_reader #(.N(N), .SETTLE(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .ctrl_done     (ctrl_done),
        .fifo_empty    (fifo_empty),
        .fifo_dout     (fifo_dout),
        .fifo_rd_en    (fifo_rd_en),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .outlier_count (outlier_count),
        .busy          (busy),
        .finished      (finished)
    );

    always #5 clock = ~clock;

    logic [N-1:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr    <= wr_ptr;
            fifo_dout <= '0;
        end else if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr[9:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    logic [31:0] got_d [0:511];
    bit          got_l [0:511];
    int          nbeats = 0;
    int          rd_pulses = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (fifo_rd_en) rd_pulses++;
            if (m_valid && m_ready && nbeats < 512) begin
                got_d[nbeats] = m_data;
                got_l[nbeats] = m_last;
                nbeats++;
            end
        end
    end

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_d [0:255];
    bit          exp_l [0:255];
    int          exp_n;
    int          base;
    int          rd0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [N-1:0] v);
        mem[wr_ptr[9:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic add_exp(input logic [31:0] d, input bit l);
        exp_d[exp_n] = d;
        exp_l[exp_n] = l;
        exp_n++;
    endtask

    task automatic pulse_start();
        base = nbeats;
        rd0  = rd_pulses;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_finished(input string tag, input int budget,
                                 input bit toggle);
        int n = 0;
        while (!finished && n < budget) begin
            if (toggle) m_ready = ~m_ready;
            step();
            n++;
        end
        check({tag, "_finish"}, finished, 1'b1);
    endtask

    task automatic check_beats(input string tag);
        check({tag, "_nbeats"}, nbeats - base, exp_n);
        for (int i = 0; i < exp_n; i++) begin
            if (base + i < nbeats) begin
                check($sformatf("%s_d%0d", tag, i), got_d[base+i], exp_d[i]);
                check($sformatf("%s_l%0d", tag, i), got_l[base+i], exp_l[i]);
            end
        end
    endtask

    initial begin
        #1;
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_m_data", m_data, 0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_count", outlier_count, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_finished", finished, 1'b0);
        step();
        step();
        reset = 1'b0;
        step();

        // Basic drain with ready high.
        push(16'd5); push(16'd9); push(16'd12);
        ctrl_done = 1'b1;
        m_ready   = 1'b1;
        exp_n = 0;
        add_exp(5, 0); add_exp(9, 0); add_exp(12, 0);
        if (TRL) add_exp(3, 1);
        pulse_start();
        check("s1_busy", busy, 1'b1);
        wait_finished("s1", 100, 1'b0);
        check_beats("s1");
        check("s1_count", outlier_count, 3);
        check("s1_idle_valid", m_valid, 1'b0);

        // Backpressure: only two reads may be outstanding.
        push(16'd5); push(16'd9); push(16'd12);
        ctrl_done = 1'b0;
        m_ready   = 1'b0;
        pulse_start();
        check("s2_count_clr", outlier_count, 0);
        check("s2_fin_clr", finished, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("s2_hold_early", m_data, 5);
        for (int i = 0; i < 5; i++) step();
        check("s2_reads", rd_pulses - rd0, 2);
        check("s2_hold_valid", m_valid, 1'b1);
        check("s2_hold_data", m_data, 5);
        exp_n = 0;
        add_exp(5, 0); add_exp(9, 0); add_exp(12, 0);
        if (TRL) add_exp(3, 1);
        m_ready   = 1'b1;
        ctrl_done = 1'b1;
        wait_finished("s2", 100, 1'b0);
        check_beats("s2");

        // 100 random positions with ready toggling every cycle.
        exp_n = 0;
        for (int i = 0; i < 100; i++) begin
            logic [N-1:0] v;
            v = N'($urandom_range(0, 65535));
            push(v);
            add_exp({16'h0, v}, 0);
        end
        if (TRL) add_exp(100, 1);
        m_ready = 1'b0;
        pulse_start();
        wait_finished("s3", 2000, 1'b1);
        check_beats("s3");
        check("s3_count", outlier_count, 100);

        // Empty session: trailer only, no reads.
        m_ready = 1'b1;
        exp_n = 0;
        if (TRL) add_exp(0, 1);
        pulse_start();
        wait_finished("s4", 100, 1'b0);
        check_beats("s4");
        check("s4_reads", rd_pulses - rd0, 0);
        check("s4_count", outlier_count, 0);

        // Late FIFO write after done is already high.
        exp_n = 0;
        add_exp(77, 0);
        if (TRL) add_exp(1, 1);
        pulse_start();
        step();
        push(16'd77);
        wait_finished("s5", 100, 1'b0);
        check_beats("s5");
        check("s5_count", outlier_count, 1);

        // Asynchronous reset with two beats buffered.
        push(16'd1); push(16'd2); push(16'd3);
        ctrl_done = 1'b0;
        m_ready   = 1'b0;
        pulse_start();
        for (int i = 0; i < 5; i++) step();
        check("s6_pre_valid", m_valid, 1'b1);
        check("s6_pre_data", m_data, 1);
        #2;
        reset = 1'b1;
        #1;
        check("s6_rd_en", fifo_rd_en, 1'b0);
        check("s6_m_data", m_data, 0);
        check("s6_m_valid", m_valid, 1'b0);
        check("s6_m_last", m_last, 1'b0);
        check("s6_count", outlier_count, 0);
        check("s6_busy", busy, 1'b0);
        check("s6_finished", finished, 1'b0);
        step();
        reset = 1'b0;
        step();
        push(16'd40); push(16'd41);
        ctrl_done = 1'b1;
        m_ready   = 1'b1;
        exp_n = 0;
        add_exp(40, 0); add_exp(41, 0);
        if (TRL) add_exp(2, 1);
        pulse_start();
        wait_finished("s6", 100, 1'b0);
        check_beats("s6");
        check("s6_count_after", outlier_count, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
